// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully connected layer: LANES neurons per group, one input element per MAC cycle.
// out = sat(relu((bias + sum(in * w)) >>> SHIFT)); weights/bias live in plain arrays loadable hierarchically.
//
// state   | meaning
// IDLE    | waiting for start; result (if any) held on output_vector
// LOAD    | seed lane accumulators with the group's biases
// MAC     | accumulate one input element per cycle across all lanes
// WRITE   | shift/relu/saturate lanes into output_vector, advance group or finish
module dense_layer_seq #(
  parameter int    IN_SIZE      = 128,
  parameter int    OUT_SIZE     = 64,
  parameter int    IN_W         = 16,
  parameter int    W_W          = 16,
  parameter int    OUT_W        = 24,
  parameter int    LANES        = 4,
  parameter int    SHIFT        = 8,
  parameter int    RELU         = 1,
  parameter string WEIGHTS_FILE = "",
  parameter string BIAS_FILE    = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [IN_W*IN_SIZE-1:0]   input_vector,
  output logic                      busy,
  output logic                      done,
  output logic                      out_valid,
  output logic [OUT_W*OUT_SIZE-1:0] output_vector
);

  localparam int PW    = IN_W + W_W;
  localparam int ACC_W = IN_W + W_W + $clog2(IN_SIZE) + 1;
  localparam int G     = OUT_SIZE / LANES;
  localparam int GW    = (G > 1) ? $clog2(G) : 1;
  localparam int IW    = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int OA    = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int WA    = $clog2(OUT_SIZE * IN_SIZE);

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_WRITE} state_t;

  logic signed [W_W-1:0]   weight_matrix [0:OUT_SIZE*IN_SIZE-1];
  logic signed [PW-1:0]    bias_vector   [0:OUT_SIZE-1];

  state_t                  state, state_nxt;
  logic [GW-1:0]           g_cnt;
  logic [IW-1:0]           i_cnt;
  logic signed [IN_W-1:0]  in_mem  [IN_SIZE];
  logic signed [ACC_W-1:0] acc     [LANES];
  logic [OUT_W-1:0]        out_mem [OUT_SIZE];

  logic                    capture_en, load_en, mac_en, write_en;
  logic                    last_i, last_g;
  logic [OA-1:0]           o_idx   [LANES];
  logic [WA-1:0]           w_idx   [LANES];
  logic signed [PW-1:0]    prod    [LANES];
  logic signed [ACC_W-1:0] shifted [LANES];
  logic [OUT_W-1:0]        sat_val [LANES];

  assign last_i = (i_cnt == IW'(IN_SIZE - 1));
  assign last_g = (g_cnt == GW'(G - 1));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_MAC;
      S_MAC:   if (last_i) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_g ? S_IDLE : S_LOAD;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    capture_en = 1'b0;
    load_en    = 1'b0;
    mac_en     = 1'b0;
    write_en   = 1'b0;
    case (state)
      S_IDLE:  capture_en = start;
      S_LOAD:  load_en    = 1'b1;
      S_MAC:   mac_en     = 1'b1;
      S_WRITE: write_en   = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      o_idx[l]   = OA'(int'(g_cnt) * LANES + l);
      w_idx[l]   = WA'((int'(g_cnt) * LANES + l) * IN_SIZE + int'(i_cnt));
      prod[l]    = in_mem[i_cnt] * weight_matrix[w_idx[l]];
      shifted[l] = acc[l] >>> SHIFT;
      sat_val[l] = shifted[l][OUT_W-1:0];
      if (RELU != 0 && shifted[l][ACC_W-1]) sat_val[l] = '0;
      else if (shifted[l] > SAT_MAX)        sat_val[l] = SAT_MAX[OUT_W-1:0];
      else if (shifted[l] < SAT_MIN)        sat_val[l] = SAT_MIN[OUT_W-1:0];
    end
  end

  // Captured inputs and accumulators need no reset: both are rewritten before use.
  always_ff @(posedge clk) begin
    if (capture_en) begin
      for (int i = 0; i < IN_SIZE; i++) in_mem[i] <= input_vector[i*IN_W +: IN_W];
    end
    for (int l = 0; l < LANES; l++) begin
      if (load_en)
        acc[l] <= {{(ACC_W-PW){bias_vector[o_idx[l]][PW-1]}}, bias_vector[o_idx[l]]};
      else if (mac_en)
        acc[l] <= acc[l] + {{(ACC_W-PW){prod[l][PW-1]}}, prod[l]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      g_cnt     <= '0;
      i_cnt     <= '0;
      for (int o = 0; o < OUT_SIZE; o++) out_mem[o] <= '0;
    end else begin
      done <= 1'b0;
      if (capture_en) begin
        g_cnt     <= '0;
        out_valid <= 1'b0;
        busy      <= 1'b1;
      end
      if (load_en) i_cnt <= '0;
      if (mac_en)  i_cnt <= last_i ? '0 : i_cnt + 1'b1;
      if (write_en) begin
        for (int l = 0; l < LANES; l++) out_mem[o_idx[l]] <= sat_val[l];
        if (last_g) begin
          done      <= 1'b1;
          out_valid <= 1'b1;
          busy      <= 1'b0;
          g_cnt     <= '0;
        end else begin
          g_cnt <= g_cnt + 1'b1;
        end
      end
    end
  end

  for (genvar o = 0; o < OUT_SIZE; o++) begin : g_pack
    assign output_vector[o*OUT_W +: OUT_W] = out_mem[o];
  end

endmodule

// File: tb/tb_dense_layer_seq.sv
// Bench for dense_layer_seq: a RELU=1 and a RELU=0 instance share stimulus; a longint
// reference model fills a scoreboard at start and results are popped on done.
module tb_dense_layer_seq;
  localparam int IN_SIZE  = 128;
  localparam int OUT_SIZE = 64;
  localparam int IN_W     = 16;
  localparam int W_W      = 16;
  localparam int OUT_W    = 24;
  localparam int LANES    = 4;
  localparam int SHIFT    = 8;
  localparam int LAT      = (OUT_SIZE / LANES) * (IN_SIZE + 2);

  typedef logic [OUT_W*OUT_SIZE-1:0] vec_t;

  logic                    clk = 1'b0;
  logic                    rst, start;
  logic [IN_W*IN_SIZE-1:0] in_vec;
  logic                    busy_r, done_r, ov_r, busy_n, done_n, ov_n;
  vec_t                    out_r, out_n;

  int     w_ref  [OUT_SIZE*IN_SIZE];
  longint b_ref  [OUT_SIZE];
  int     in_ref [IN_SIZE];
  vec_t   exp_r_q[$];
  vec_t   exp_n_q[$];
  int     n_cmp = 0;
  int     n_mis = 0;

  always #5 clk = ~clk;

  dense_layer_seq #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(IN_W), .W_W(W_W),
                    .OUT_W(OUT_W), .LANES(LANES), .SHIFT(SHIFT), .RELU(1)) dut_r (
    .clk(clk), .rst(rst), .start(start), .input_vector(in_vec),
    .busy(busy_r), .done(done_r), .out_valid(ov_r), .output_vector(out_r));

  dense_layer_seq #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .IN_W(IN_W), .W_W(W_W),
                    .OUT_W(OUT_W), .LANES(LANES), .SHIFT(SHIFT), .RELU(0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .input_vector(in_vec),
    .busy(busy_n), .done(done_n), .out_valid(ov_n), .output_vector(out_n));

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t model(bit relu);
    vec_t   res;
    longint acc, r;
    res = '0;
    for (int o = 0; o < OUT_SIZE; o++) begin
      acc = b_ref[o];
      for (int i = 0; i < IN_SIZE; i++)
        acc += longint'(in_ref[i]) * longint'(w_ref[o*IN_SIZE + i]);
      r = acc >>> SHIFT;
      if (relu && r < 0) r = 0;
      if (r > 64'sd8388607)  r = 64'sd8388607;
      if (r < -64'sd8388608) r = -64'sd8388608;
      res[o*OUT_W +: OUT_W] = OUT_W'(r);
    end
    return res;
  endfunction

  task automatic load_mem();
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) begin
      dut_r.weight_matrix[k] = W_W'(w_ref[k]);
      dut_n.weight_matrix[k] = W_W'(w_ref[k]);
    end
    for (int o = 0; o < OUT_SIZE; o++) begin
      dut_r.bias_vector[o] = (IN_W+W_W)'(b_ref[o]);
      dut_n.bias_vector[o] = (IN_W+W_W)'(b_ref[o]);
    end
  endtask

  task automatic drive_and_push();
    for (int i = 0; i < IN_SIZE; i++) in_vec[i*IN_W +: IN_W] = IN_W'(in_ref[i]);
    exp_r_q.push_back(model(1'b1));
    exp_n_q.push_back(model(1'b0));
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (cyc < LAT + 100) begin
      tick();
      cyc++;
      if (done_r) break;
    end
    chk("done_seen_r", done_r, 1);
    chk("done_seen_n", done_n, 1);
  endtask

  task automatic check_result(input string tag);
    vec_t er, en;
    chk({tag, "_sb_depth"}, exp_r_q.size(), 1);
    if (exp_r_q.size() > 0 && exp_n_q.size() > 0) begin
      er = exp_r_q.pop_front();
      en = exp_n_q.pop_front();
      for (int o = 0; o < OUT_SIZE; o++) begin
        chk($sformatf("%s_r_out%0d", tag, o), $signed(out_r[o*OUT_W +: OUT_W]), $signed(er[o*OUT_W +: OUT_W]));
        chk($sformatf("%s_n_out%0d", tag, o), $signed(out_n[o*OUT_W +: OUT_W]), $signed(en[o*OUT_W +: OUT_W]));
      end
    end
    chk({tag, "_out_valid"}, ov_r, 1);
    chk({tag, "_busy_low"}, busy_r, 0);
  endtask

  task automatic run_basic(input string tag);
    int cyc;
    drive_and_push();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_high"}, busy_r, 1);
    wait_done(cyc);
    chk({tag, "_latency"}, cyc, LAT);
    check_result(tag);
    tick();
    chk({tag, "_done_pulse"}, done_r, 0);
  endtask

  task automatic rand_inputs();
    logic [15:0] t;
    for (int i = 0; i < IN_SIZE; i++) begin
      t = 16'($urandom);
      in_ref[i] = int'($signed(t));
    end
  endtask

  task automatic set_weights(input int val);
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) w_ref[k] = val;
  endtask

  initial begin
    int cyc;
    rst    = 1'b0;
    start  = 1'b1;
    in_vec = '0;

    // reset with start asserted
    repeat (3) tick();
    chk("rst_busy", busy_r, 0);
    chk("rst_done", done_r, 0);
    chk("rst_out_valid", ov_r, 0);
    chk("rst_out_r", (out_r == '0), 1);
    chk("rst_out_n", (out_n == '0), 1);
    start = 1'b0;
    rst   = 1'b1;
    tick();
    chk("rst_no_start", busy_r, 0);

    // bias path and latency
    rand_inputs();
    set_weights(0);
    for (int o = 0; o < OUT_SIZE; o++) b_ref[o] = longint'(o) * 256;
    load_mem();
    run_basic("bias");

    // MAC: ones everywhere, output 5 uses weight 2
    for (int i = 0; i < IN_SIZE; i++) in_ref[i] = 256;
    set_weights(1);
    for (int i = 0; i < IN_SIZE; i++) w_ref[5*IN_SIZE + i] = 2;
    for (int o = 0; o < OUT_SIZE; o++) b_ref[o] = 0;
    load_mem();
    run_basic("mac");

    // negative results: relu vs pass-through
    set_weights(-1);
    load_mem();
    run_basic("neg");

    // saturation both directions
    for (int i = 0; i < IN_SIZE; i++) in_ref[i] = 32767;
    set_weights(32767);
    load_mem();
    run_basic("sat_pos");
    set_weights(-32768);
    load_mem();
    run_basic("sat_neg");

    // start mid-run and input change after accept must not disturb
    rand_inputs();
    for (int k = 0; k < OUT_SIZE*IN_SIZE; k++) w_ref[k] = int'($urandom_range(0, 127)) - 64;
    for (int o = 0; o < OUT_SIZE; o++) b_ref[o] = longint'($urandom_range(0, 65535)) - 32768;
    load_mem();
    drive_and_push();
    start = 1'b1;
    tick();
    start  = 1'b0;
    in_vec = ~in_vec;
    repeat (300) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cyc);
    chk("disturb_latency", cyc + 301, LAT);
    check_result("disturb");
    tick();

    // reset mid-computation, then a fresh run
    rand_inputs();
    for (int i = 0; i < IN_SIZE; i++) in_vec[i*IN_W +: IN_W] = IN_W'(in_ref[i]);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (999) tick();
    rst = 1'b0;
    tick();
    chk("midrst_busy", busy_r, 0);
    chk("midrst_done", done_r, 0);
    chk("midrst_out_valid", ov_n, 0);
    chk("midrst_out_r", (out_r == '0), 1);
    chk("midrst_out_n", (out_n == '0), 1);
    rst = 1'b1;
    tick();
    chk("midrst_idle", busy_n, 0);
    run_basic("after_rst");

    // start held high: back-to-back computations
    rand_inputs();
    drive_and_push();
    start = 1'b1;
    tick();
    wait_done(cyc);
    chk("held_latency1", cyc, LAT);
    check_result("held1");
    drive_and_push();
    tick();
    start = 1'b0;
    chk("held_rebusy", busy_r, 1);
    chk("held_ov_clear", ov_r, 0);
    chk("held_done_low", done_r, 0);
    wait_done(cyc);
    chk("held_latency2", cyc, LAT);
    check_result("held2");
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
